// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    R_WB,
    ADDR,
    MEM_RD,
    LD_WB,
    MEM_WR,
    BRANCH,
    TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;

  // Moore (state-only) control outputs.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       fault;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore output decode for a given state; anything not listed stays 0.
  function automatic ctrl_t moore_outs(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      R_WB:   c.reg_write = 1'b1;
      ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      LD_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.i_or_d  = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = 1'b1;
      end
      TRAP:    c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait watchdog: down-counter reloaded whenever the FSM is not
// stalled on mem_ready, expiring on the TIMEOUT_CYCLES-th stalled cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TCNT_W         = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam logic [TCNT_W-1:0] TOP = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] cnt;

  // Reload outside a stall (covers every state change), count down while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= TOP;
    end else if (!waiting) begin
      cnt <= TOP;
    end else if (cnt != '0) begin
      cnt <= cnt - TCNT_W'(1);
    end
  end

  assign expired = waiting && (cnt == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback over a shared datapath. Optional memory wait timeout is built
// when WAIT_TIMEOUT_EN is defined; otherwise memory waits are unbounded.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TCNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       fault
);

  if ((TIMEOUT_CYCLES == 0) || ((2 ** TCNT_W) <= TIMEOUT_CYCLES)) begin : g_param_check
    $error("multicycle_control: TCNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t state, nxt;
  ctrl_t  ctrl_q;
  logic   is_store;
  logic   in_wait;
  logic   timeout;

  assign in_wait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

`ifdef WAIT_TIMEOUT_EN
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TCNT_W        (TCNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(in_wait && !mem_ready),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state selection; a completed handshake always beats a timeout.
  always_comb begin
    nxt = state;
    unique case (state)
      FETCH: begin
        if (mem_ready)    nxt = DECODE;
        else if (timeout) nxt = TRAP;
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:          nxt = EXEC_R;
          OP_LOAD, OP_STORE: nxt = ADDR;
          OP_BRANCH:         nxt = BRANCH;
          default:           nxt = TRAP;
        endcase
      end
      EXEC_R: nxt = R_WB;
      R_WB:   nxt = FETCH;
      ADDR:   nxt = is_store ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)    nxt = LD_WB;
        else if (timeout) nxt = TRAP;
      end
      LD_WB:  nxt = FETCH;
      MEM_WR: begin
        if (mem_ready)    nxt = FETCH;
        else if (timeout) nxt = TRAP;
      end
      BRANCH: nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  // State, registered Moore outputs, and the load/store flag captured in DECODE
  // (opcode is only trusted in DECODE, so ADDR uses the captured flag).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      ctrl_q   <= moore_outs(FETCH);
      is_store <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= moore_outs(nxt);
      if (state == DECODE) is_store <= (opcode == OP_STORE);
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_we     = ctrl_q.mem_we;
  assign i_or_d     = ctrl_q.i_or_d;
  assign pc_src     = ctrl_q.pc_src;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign fault      = ctrl_q.fault;

  // Handshake-qualified strobes; held low during reset so nothing commits.
  assign ir_write = !reset && (state == FETCH) && mem_ready;
  assign pc_write = !reset && (((state == FETCH) && mem_ready) ||
                               ((state == BRANCH) && zero));

endmodule
